clk_div_gen: RTL
================

Name: clk_div_gen

Overview:
Parametrised integer clock divider, next generation of the team's ClkDiv. Divides i_ref_clk by a runtime ratio up to 2^RATIO_WIDTH-1. Adds a pulse/duty mode, a one-cycle tick output, and glitch-free ratio changes applied only at period boundaries. Feeds UART/peripheral clocking, and bypasses to the reference clock when disabled.

Parameters:
RATIO_WIDTH, 8, width of i_div_ratio, the internal period counter and o_active_ratio.

Ports:
i_ref_clk  input  1  reference clock; all state updates on its rising edge
i_rst  input  1  reset, synchronous, active-high
i_clk_enable  input  1  1 = divide, 0 = bypass after the current period completes
i_div_ratio  input  RATIO_WIDTH  requested division ratio N; values 0 and 1 mean bypass
i_mode  input  1  0 = near-50% duty; 1 = pulse (high one ref cycle per period)
o_div_clk  output  1  divided clock; equals i_ref_clk in bypass
o_div_tick  output  1  high for the first ref cycle of every divided period
o_active_ratio  output  RATIO_WIDTH  ratio currently in use; 0 in bypass

Behaviour:
- State machine with two states:
  - IDLE: bypass. o_div_clk = i_ref_clk through a combinational mux selected by a registered state bit. o_div_tick = 0, o_active_ratio = 0.
  - RUN: dividing.
- Reset: on a rising edge with i_rst=1:
  - state<=IDLE, cnt<=0, div_reg<=0, tick<=0, active ratio<=0, active mode<=0.
  - i_rst dominates all other inputs.
  - Reset mid-RUN aborts the period immediately; bypass applies from the following cycle.
- Period: cnt counts 0..N-1, where N is the active ratio.
- IDLE->RUN: at an edge with i_clk_enable=1 and i_div_ratio>=2:
  - latch N<=i_div_ratio and M<=i_mode;
  - cnt<=0, tick<=1, div_reg<=1.
  - The first divided period starts at that edge, so latency is one ref edge.
- Output in RUN, registered (no combinational path from inputs):
  - During the ref cycle with cnt=k, o_div_clk = (k < H) and o_div_tick = (k == 0).
  - Mode 0: H = floor(N/2). Odd N gives high floor(N/2) cycles and low ceil(N/2) cycles, e.g. N=5 gives 2 high / 3 low.
  - Mode 1: H = 1.
- Boundary edge (cnt = N-1):
  - If i_clk_enable=1 and i_div_ratio>=2: reload N and M from the inputs, cnt<=0, next period begins.
  - Otherwise: state<=IDLE and bypass starts from the next cycle.
  - Input changes at any other time are ignored until the boundary, so no runt pulses are generated.
- Non-boundary edges in RUN: cnt<=cnt+1.
- Max ratio 2^RATIO_WIDTH-1. The counter never exceeds N-1, so there is no wrap.
- o_active_ratio = latched N in RUN; it updates at the reload edge.
- N=2 in mode 0 and mode 1 give identical waveforms (1 high / 1 low).
- Enable dropped and raised again within one period: no visible effect; the inputs are sampled only at the boundary.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_clk_enable=1, i_div_ratio=4 -> o_div_clk mirrors i_ref_clk, o_div_tick=0, o_active_ratio=0. RUN is entered at the first edge after i_rst=0.
- Even ratio: T=10ns, ratio 4, mode 0 -> o_div_clk period 40ns (20ns high / 20ns low). o_div_tick is a 10ns pulse every 40ns, aligned with the rising edge of o_div_clk. o_active_ratio=4.
- Odd and extreme ratios: ratio 5 -> 20ns high / 30ns low. ratio 255 -> 1270ns high / 1280ns low. ratio 2 -> 10/10ns. ratio 0 or 1 with enable=1 -> bypass.
- Pulse mode: ratio 6, i_mode=1 -> high 10ns, low 50ns. Toggling i_mode mid-period changes the shape only from the next period.
- Ratio change mid-period: running ratio 4, change to 3 at cnt=1 -> current period stays 4 cycles, next periods are 3 cycles (10 high / 20 low). o_active_ratio changes 4->3 at the boundary edge.
- Disable and reset mid-run:
  - Ratio 8, i_clk_enable<=0 at cnt=2 -> the full 8-cycle period completes, then bypass with o_active_ratio=0.
  - Separately, i_rst=1 at cnt=3 -> bypass from the next cycle, with no further o_div_tick.

Source files
------------

// File: rtl/clk_div_gen.sv
// clk_div_gen: runtime-programmable integer clock divider.
// Divides i_ref_clk by N (2..2^RATIO_WIDTH-1) with near-50% or single-pulse duty.
// New ratio, mode and enable values are taken only at period boundaries, so a
// period that has started always completes with its original shape.
// In bypass (IDLE) the reference clock is passed straight through.
module clk_div_gen #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_enable,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    input  logic                   i_mode,
    output logic                   o_div_clk,
    output logic                   o_div_tick,
    output logic [RATIO_WIDTH-1:0] o_active_ratio
);

    // Two-state controller: bypass or dividing.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [RATIO_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [RATIO_WIDTH-1:0] CNT_ONE   = RATIO_WIDTH'(1);
    localparam logic [RATIO_WIDTH-1:0] RATIO_MIN = RATIO_WIDTH'(2);

    // Registered state.
    logic [0:0]             state;
    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic                   mode_q;
    logic                   div_reg;
    logic                   tick_reg;

    // Next-state values.
    logic [0:0]             state_nxt;
    logic [RATIO_WIDTH-1:0] cnt_nxt;
    logic [RATIO_WIDTH-1:0] ratio_nxt;
    logic                   mode_nxt;
    logic                   div_nxt;
    logic                   tick_nxt;

    // Decoded conditions.
    logic                   start_ok;
    logic                   at_boundary;
    logic [RATIO_WIDTH-1:0] cnt_inc;

    // Number of ref cycles the divided clock stays high in one period.
    // Mode 0 keeps floor(N/2) high, so odd ratios are one cycle longer low.
    function automatic logic [RATIO_WIDTH-1:0] high_time(
        input logic [RATIO_WIDTH-1:0] n,
        input logic                   m
    );
        return m ? CNT_ONE : (n >> 1);
    endfunction

    // A new period may begin only with the divider enabled and a real ratio;
    // 0 and 1 both request bypass.
    assign start_ok    = i_clk_enable && (i_div_ratio >= RATIO_MIN);
    assign at_boundary = (cnt == (ratio_q - CNT_ONE));
    assign cnt_inc     = cnt + CNT_ONE;

    // Next-state logic: count within a period, reload or fall back to bypass
    // at the boundary, start dividing from bypass when requested.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        ratio_nxt = ratio_q;
        mode_nxt  = mode_q;
        div_nxt   = div_reg;
        tick_nxt  = tick_reg;

        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    // First period starts at this very edge; H is always
                    // at least 1 for N >= 2, so cycle 0 is high.
                    state_nxt = ST_RUN;
                    ratio_nxt = i_div_ratio;
                    mode_nxt  = i_mode;
                    cnt_nxt   = CNT_ZERO;
                    div_nxt   = 1'b1;
                    tick_nxt  = 1'b1;
                end
            end

            ST_RUN: begin
                if (!at_boundary) begin
                    // Mid-period: inputs are ignored, shape follows the
                    // latched ratio and mode.
                    cnt_nxt  = cnt_inc;
                    div_nxt  = (cnt_inc < high_time(ratio_q, mode_q));
                    tick_nxt = 1'b0;
                end else if (start_ok) begin
                    // Seamless reload: next period uses the new settings.
                    ratio_nxt = i_div_ratio;
                    mode_nxt  = i_mode;
                    cnt_nxt   = CNT_ZERO;
                    div_nxt   = 1'b1;
                    tick_nxt  = 1'b1;
                end else begin
                    // Period finished and dividing no longer requested.
                    state_nxt = ST_IDLE;
                    ratio_nxt = CNT_ZERO;
                    mode_nxt  = 1'b0;
                    cnt_nxt   = CNT_ZERO;
                    div_nxt   = 1'b0;
                    tick_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                ratio_nxt = CNT_ZERO;
                mode_nxt  = 1'b0;
                cnt_nxt   = CNT_ZERO;
                div_nxt   = 1'b0;
                tick_nxt  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge i_ref_clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= CNT_ZERO;
            ratio_q  <= CNT_ZERO;
            mode_q   <= 1'b0;
            div_reg  <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ratio_q  <= ratio_nxt;
            mode_q   <= mode_nxt;
            div_reg  <= div_nxt;
            tick_reg <= tick_nxt;
        end
    end

    // Output mux: registered divided clock in RUN, reference clock in bypass.
    // The select is a register, so the only combinational path is the bypass.
    assign o_div_clk      = (state == ST_RUN) ? div_reg : i_ref_clk;
    assign o_div_tick     = tick_reg;
    assign o_active_ratio = ratio_q;

endmodule
